// File: rtl/sync_event_arbiter.sv
// Synchronises N asynchronous request lines, detects rising edges, holds one
// pending event per channel and serialises them onto a valid/ready port in round-robin order.
`timescale 1ns/1ps

module sync_event_arbiter #(
  parameter  int N           = 4,
  parameter  int SYNC_STAGES = 3,
  localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_async,
  output logic          o_valid,
  output logic [IW-1:0] o_id,
  input  logic          i_ready,
  output logic [N-1:0]  o_overflow,
  input  logic [N-1:0]  i_ovf_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic [N-1:0][SYNC_STAGES-1:0] sync_q;

  logic [N-1:0]  dly_q;
  logic [N-1:0]  sync_s;
  logic [N-1:0]  edge_p;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_d;
  logic [N-1:0]  ovf_q;
  logic [N-1:0]  ovf_d;
  logic [N-1:0]  load_oh;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] winner;
  logic          found;
  logic          load;
  state_t        state_q;
  state_t        state_d;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sync_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign edge_p = sync_s & ~dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], i_async[i]};
      end
      dly_q <= sync_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: pointer+1, pointer+2, ... modulo N
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && pending_q[j] && (((int'(ptr_q) + k) % N) == j)) begin
          found  = 1'b1;
          winner = IW'(j);
        end
      end
    end
  end

  // A new event is loaded from IDLE unconditionally, from OFFER only on handshake.
  assign load = found && ((state_q == IDLE) || i_ready);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      load_oh[i] = load && (winner == IW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slots and sticky overflow flags
  // ---------------------------------------------------------------------------
  // An edge on the load cycle refills the slot that is being emptied.
  assign pending_d = edge_p | (pending_q & ~load_oh);
  assign ovf_d     = (edge_p & pending_q & ~load_oh) | (ovf_q & ~i_ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = OFFER;
      OFFER:   if (i_ready && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N - 1);
      o_id    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ptr_q <= winner;
        o_id  <= winner;
      end
    end
  end

  // Derived from the state flop so reset drops it without waiting for clk.
  assign o_valid = (state_q == OFFER);

endmodule

// File: doc/sync_event_arbiter.md
Name: sync_event_arbiter

Overview:
Collects rising-edge events from N asynchronous request lines and synchronises each line through a SYNC_STAGES-deep flop chain. Each event is held in a one-deep pending slot per channel. Pending events are serialised onto a single valid/ready event port by a round-robin arbiter. It sits at the boundary between external/async status lines (buttons, foreign-clock strobes, IRQs) and the soft-CPU/peripheral logic in the clk domain.

Parameters:
N, 4, number of asynchronous request channels (1..16)
SYNC_STAGES, 3, synchroniser depth per channel (>= 2); all chain flops carry ASYNC_REG = "TRUE"

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
i_async  input  N  asynchronous request lines, one per channel; rising edge = one event
o_valid  output  1  event offered on o_id
o_id  output  max(1,$clog2(N))  channel number of offered event
i_ready  input  1  consumer accepts event when high with o_valid at a clk edge
o_overflow  output  N  sticky per-channel flag: event lost because the pending slot was full
i_ovf_clr  input  N  write-1-to-clear for o_overflow, sampled each edge

Behaviour:
- Reset (rst_n low, takes effect immediately without clk): all sync flops, edge-delay flops, pending, o_valid, o_id and o_overflow = 0; RR pointer = N-1, so channel 0 has first priority.
- Synchroniser: per channel, SYNC_STAGES flops then one delay flop d[i]; s[i] = last stage; edge[i] = s[i] & ~d[i] (single-cycle pulse).
- A line already high at reset release counts as one event, because the chain rises from its reset value of 0.
- Latency: i_async rise first captured at edge 0 -> edge[i] high after edge SYNC_STAGES-1 -> pending[i] set at edge SYNC_STAGES -> o_valid high after edge SYNC_STAGES+1 (4 cycles with default SYNC_STAGES=3), if the arbiter is idle.
- Pending: pending[i] is set by edge[i] and cleared when channel i is loaded into the output register. Load and edge on the same edge -> pending[i] stays 1; no overflow.
- Overflow: edge[i] while pending[i]=1 and channel i is not loaded at that edge -> event dropped, o_overflow[i] <= 1. Simultaneous set and i_ovf_clr[i] -> set wins.
- FSM IDLE:
  - o_valid=0.
  - If any pending: select winner by RR, load o_id <= winner, clear pending[winner], o_valid <= 1, pointer <= winner, go OFFER.
- FSM OFFER:
  - o_valid=1; o_id stable until handshake.
  - On edge with i_ready=1 and any pending: load next RR winner in the same edge (back-to-back, o_valid stays 1).
  - On edge with i_ready=1 and nothing pending: o_valid <= 0, go IDLE.
  - i_ready=0: hold.
- RR search order: pointer+1, pointer+2, ... modulo N; first pending channel wins. Pointer updates only on load.
- Throughput: 1 event per cycle max with i_ready held high.
- Reset mid-operation: pending and offered events are discarded; o_valid drops asynchronously; no partial handshake completes.
- i_ready is ignored when o_valid=0.
- i_async has no timing relationship to clk; all other inputs are synchronous to clk.

Test Plan:
1. N=4, S=3, idle, i_ready=1; i_async[2] pulses high 3 cycles -> o_valid high exactly 1 cycle starting after the 4th edge from capture, o_id=2; no further events; o_overflow=0.
2. i_async[3:0] rise in the same cycle, i_ready=1 -> o_id sequence 0,1,2,3 on consecutive cycles, o_valid high 4 cycles, then 0.
3. Back-to-back fairness: ch1 and ch3 each produce a new rising edge every 6 cycles, i_ready=1 -> grants alternate 1,3,1,3…; neither channel is granted twice in a row while the other is pending.
4. Backpressure: i_ready=0; ch0 event offered; ch1 gets 2 edges 8 cycles apart -> o_id=0 held stable 20 cycles, o_overflow[1]=1. Release i_ready -> exactly one ch1 event follows. i_ovf_clr[1]=1 for 1 cycle -> o_overflow[1]=0.
5. Coincidence: ch0 pending and being loaded in the same edge that edge[0] fires -> after handshake a second ch0 event is offered; o_overflow[0]=0. Repeat with edge[0] and i_ovf_clr[0] on the same edge while the slot is full -> o_overflow[0]=1.
6. Assert rst_n low mid-OFFER between clk edges -> o_valid=0 and o_overflow=0 immediately. Hold i_async[1] high through reset, then release -> exactly one ch1 event, offered SYNC_STAGES+2 edges after release; o_id=1.
